// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port 32-bit SRAM between a read-only instruction port
//   and a read/write data port. Grants are combinational in the request
//   cycle; the read response (rvalid) follows exactly one cycle later, so a
//   new access can be accepted every cycle.
//
// Build option:
//   SRAM_ARB_ROUND_ROBIN_EN  defined   -> contested cycles alternate between
//                                         ports (data wins the first contest
//                                         after reset).
//                            undefined -> data port always wins contests.
//
// Ports:
//   clk_sys, rst_sys_n            clock, async active-low reset
//   instr_req_i/addr_i            instruction request, byte address
//   instr_gnt_o/rvalid_o/rdata_o  instruction grant and read response
//   data_req_i/we_i/be_i/addr_i/wdata_i   data request
//   data_gnt_o/rvalid_o/rdata_o   data grant and response
//   mem_req_o/we_o/be_o/addr_o/wdata_o    SRAM request (word address)
//   mem_rdata_i                   SRAM read data, one cycle after mem_req_o
//
// State table:
//   IDLE  | no response due this cycle
//   RSP_I | instruction access accepted last cycle, instr_rvalid_o high
//   RSP_D | data access accepted last cycle, data_rvalid_o high

module sram_port_arbiter #(
    parameter int MemDepth = 16384,
    parameter int AW       = $clog2(MemDepth)
) (
    input  logic          clk_sys,
    input  logic          rst_sys_n,

    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,

    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    output logic [31:0]   data_rdata_o,

    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RSP_I = 2'd1,
        RSP_D = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   instr_win;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // 1 = instr won the last contest, 0 = data won it.
    logic last_winner_q;

    // Contested: the port that did not win last time is served.
    assign instr_win = instr_req_i & (~data_req_i | ~last_winner_q);
`else
    assign instr_win = instr_req_i & ~data_req_i;
`endif

    assign instr_gnt_o = instr_win;
    assign data_gnt_o  = data_req_i & ~instr_win;
    assign mem_req_o   = instr_gnt_o | data_gnt_o;

    // Upper address bits wrap modulo MemDepth; byte offset is ignored.
    assign mem_addr_o  = data_gnt_o ? data_addr_i[AW+1:2] : instr_addr_i[AW+1:2];
    assign mem_we_o    = data_gnt_o & data_we_i;
    assign mem_be_o    = data_gnt_o ? data_be_i    : 4'b0000;
    assign mem_wdata_o = data_gnt_o ? data_wdata_i : 32'h0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[31:AW+2], instr_addr_i[1:0],
                                data_addr_i[31:AW+2], data_addr_i[1:0]};

    assign instr_rdata_o = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;

    always_comb begin
        state_d = IDLE;
        if (instr_gnt_o) begin
            state_d = RSP_I;
        end else if (data_gnt_o) begin
            state_d = RSP_D;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q <= IDLE;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_winner_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            if (instr_req_i && data_req_i) begin
                last_winner_q <= instr_win;
            end
`endif
        end
    end

    // Decoded straight from the state register, so reset clears both at once.
    assign instr_rvalid_o = (state_q == RSP_I);
    assign data_rvalid_o  = (state_q == RSP_D);

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    localparam int MemDepth = 16384;
    localparam int AW       = $clog2(MemDepth);

    logic          clk_sys;
    logic          rst_sys_n;
    logic          instr_req_i;
    logic [31:0]   instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [31:0]   instr_rdata_o;
    logic          data_req_i;
    logic          data_we_i;
    logic [3:0]    data_be_i;
    logic [31:0]   data_addr_i;
    logic [31:0]   data_wdata_i;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic [31:0]   data_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sram_port_arbiter #(.MemDepth(MemDepth)) dut (
        .clk_sys        (clk_sys),
        .rst_sys_n      (rst_sys_n),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // SRAM model: word i preloaded with 0xA500_0000 | i.
    logic [31:0] ram [MemDepth];
    initial begin
        for (int i = 0; i < MemDepth; i++) ram[i] = 32'hA500_0000 | i;
        mem_rdata_i = 32'h0;
    end
    always @(posedge clk_sys) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= ram[mem_addr_o];
            end
        end
    end

    task automatic idle_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'b0000;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        idle_inputs();
        rst_sys_n = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_sys_n = 1'b0;
        #2;
        total_cnt++;
        if (instr_rvalid_o !== 1'b0) $display("FAIL reset_instr_rvalid got %0b exp 0", instr_rvalid_o);
        else pass_cnt++;
        total_cnt++;
        if (data_rvalid_o !== 1'b0) $display("FAIL reset_data_rvalid got %0b exp 0", data_rvalid_o);
        else pass_cnt++;
        total_cnt++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o} !== 3'b000)
            $display("FAIL reset_grants got %03b exp 000", {mem_req_o, instr_gnt_o, data_gnt_o});
        else pass_cnt++;
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        @(negedge clk_sys);
        #1;
        total_cnt++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b00)
            $display("FAIL post_reset_rvalid got %02b exp 00", {instr_rvalid_o, data_rvalid_o});
        else pass_cnt++;
    endtask

    task automatic test_instr_only();
        @(negedge clk_sys);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0080;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (c < 3) begin
                total_cnt++;
                if ({instr_gnt_o, data_gnt_o, mem_req_o} !== 3'b101)
                    $display("FAIL instr_only_gnt c%0d got %03b exp 101", c, {instr_gnt_o, data_gnt_o, mem_req_o});
                else pass_cnt++;
                total_cnt++;
                if (mem_addr_o !== 14'h0020 || mem_we_o !== 1'b0 || mem_be_o !== 4'b0000 || mem_wdata_o !== 32'h0)
                    $display("FAIL instr_only_mem c%0d got addr %0h we %0b be %0h wd %0h exp addr 20 we 0 be 0 wd 0",
                             c, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (mem_req_o !== 1'b0) $display("FAIL instr_only_idle_req got %0b exp 0", mem_req_o);
                else pass_cnt++;
            end
            if (c > 0) begin
                total_cnt++;
                if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'hA500_0020)
                    $display("FAIL instr_only_rsp c%0d got rv %0b rd %0h exp rv 1 rd a5000020", c, instr_rvalid_o, instr_rdata_o);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (instr_rvalid_o !== 1'b0) $display("FAIL instr_only_rv_c0 got %0b exp 0", instr_rvalid_o);
                else pass_cnt++;
            end
            @(negedge clk_sys);
            if (c == 2) idle_inputs();
        end
        #1;
        total_cnt++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b00)
            $display("FAIL idle_no_rvalid got %02b exp 00", {instr_rvalid_o, data_rvalid_o});
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        @(negedge clk_sys);
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'b1111;
        data_addr_i  = 32'h0000_0100;
        data_wdata_i = 32'hDEAD_BEEF;
        #1;
        total_cnt++;
        if ({data_gnt_o, instr_gnt_o} !== 2'b10 || mem_addr_o !== 14'h0040 || mem_we_o !== 1'b1 ||
            mem_be_o !== 4'hF || mem_wdata_o !== 32'hDEAD_BEEF)
            $display("FAIL write_mem got gnt %02b addr %0h we %0b be %0h wd %0h exp gnt 10 addr 40 we 1 be f wd deadbeef",
                     {data_gnt_o, instr_gnt_o}, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
        else pass_cnt++;
        @(negedge clk_sys);
        data_we_i    = 1'b0;
        data_be_i    = 4'b0000;
        data_wdata_i = 32'h0;
        #1;
        total_cnt++;
        if (data_rvalid_o !== 1'b1) $display("FAIL write_rsp got %0b exp 1", data_rvalid_o);
        else pass_cnt++;
        total_cnt++;
        if (mem_we_o !== 1'b0 || data_gnt_o !== 1'b1) $display("FAIL read_gnt got we %0b gnt %0b exp we 0 gnt 1", mem_we_o, data_gnt_o);
        else pass_cnt++;
        @(negedge clk_sys);
        idle_inputs();
        #1;
        total_cnt++;
        if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'hDEAD_BEEF)
            $display("FAIL read_back got rv %0b rd %0h exp rv 1 rd deadbeef", data_rvalid_o, data_rdata_o);
        else pass_cnt++;
    endtask

    task automatic test_contest();
        logic [3:0] exp_i;
        do_reset();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_i = 4'b1010;  // bit c: instr wins cycle c (D,I,D,I)
`else
        exp_i = 4'b0000;
`endif
        @(negedge clk_sys);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0010;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h0000_0020;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c < 4) begin
                total_cnt++;
                if ({instr_gnt_o, data_gnt_o} !== {exp_i[c], ~exp_i[c]})
                    $display("FAIL contest_gnt c%0d got i%0b d%0b exp i%0b d%0b", c, instr_gnt_o, data_gnt_o, exp_i[c], ~exp_i[c]);
                else pass_cnt++;
                total_cnt++;
                if (mem_addr_o !== (exp_i[c] ? 14'h0004 : 14'h0008))
                    $display("FAIL contest_addr c%0d got %0h exp %0h", c, mem_addr_o, exp_i[c] ? 14'h0004 : 14'h0008);
                else pass_cnt++;
            end
            if (c > 0) begin
                total_cnt++;
                if ({instr_rvalid_o, data_rvalid_o} !== {exp_i[c-1], ~exp_i[c-1]} ||
                    mem_rdata_i !== (exp_i[c-1] ? 32'hA500_0004 : 32'hA500_0008))
                    $display("FAIL contest_rsp c%0d got i%0b d%0b rd %0h exp i%0b d%0b", c,
                             instr_rvalid_o, data_rvalid_o, mem_rdata_i, exp_i[c-1], ~exp_i[c-1]);
                else pass_cnt++;
            end
            @(negedge clk_sys);
            if (c == 3) idle_inputs();
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_sys);
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_0030;
        @(negedge clk_sys);
        idle_inputs();
        rst_sys_n = 1'b0;
        #1;
        total_cnt++;
        if (data_rvalid_o !== 1'b0) $display("FAIL mid_reset_rvalid got %0b exp 0", data_rvalid_o);
        else pass_cnt++;
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_sys);
            #1;
            total_cnt++;
            if ({instr_rvalid_o, data_rvalid_o} !== 2'b00)
                $display("FAIL after_reset_rvalid c%0d got %02b exp 00", c, {instr_rvalid_o, data_rvalid_o});
            else pass_cnt++;
        end
    endtask

    task automatic test_addr_wrap();
        logic [31:0] wrap_data;
        @(negedge clk_sys);
        data_req_i  = 1'b1;
        data_addr_i = 32'h0001_0004;
        #1;
        total_cnt++;
        if (mem_addr_o !== 14'h0001) $display("FAIL wrap_addr got %0h exp 1", mem_addr_o);
        else pass_cnt++;
        @(negedge clk_sys);
        data_addr_i = 32'h0000_0004;
        #1;
        wrap_data = data_rdata_o;
        total_cnt++;
        if (data_rvalid_o !== 1'b1 || wrap_data !== 32'hA500_0001)
            $display("FAIL wrap_rdata got rv %0b rd %0h exp rv 1 rd a5000001", data_rvalid_o, wrap_data);
        else pass_cnt++;
        @(negedge clk_sys);
        idle_inputs();
        #1;
        total_cnt++;
        if (data_rdata_o !== wrap_data || data_rvalid_o !== 1'b1)
            $display("FAIL wrap_alias got rd %0h exp %0h", data_rdata_o, wrap_data);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_instr_only();
        test_write_read();
        test_contest();
        test_reset_mid();
        test_addr_wrap();
        @(negedge clk_sys);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter MemDepth, default 16384, memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter AW, default $clog2(MemDepth), word-address width.
REQ-003 SHALL have clk_sys  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have rst_sys_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have instr_req_i  input  1; instr_addr_i  input  32  byte address; instr_gnt_o  output  1; instr_rvalid_o  output  1; instr_rdata_o  output  32.
REQ-006 SHALL have data_req_i  input  1; data_we_i  input  1; data_be_i  input  4; data_addr_i  input  32; data_wdata_i  input  32; data_gnt_o  output  1; data_rvalid_o  output  1; data_rdata_o  output  32.
REQ-007 SHALL have mem_req_o  output  1; mem_we_o  output  1; mem_be_o  output  4; mem_addr_o  output  AW  word address; mem_wdata_o  output  32; mem_rdata_i  input  32  valid one cycle after accepted mem_req_o.

Function
REQ-008 SHALL share one single-port SRAM between instruction (read-only) and data ports; at most one grant per cycle.
REQ-009 Grant SHALL be combinational, same cycle as req: requester selected -> its gnt_o=1, other gnt_o=0.
REQ-010 mem_req_o SHALL equal OR of gnt outputs; mem_addr_o = selected addr[AW+1:2] (upper bits ignored, wrap modulo MemDepth).
REQ-011 Instr grant SHALL drive mem_we_o=0, mem_be_o=4'b0000, mem_wdata_o=0; data grant SHALL pass data_we_i/be/wdata.
REQ-012 Response state machine: states IDLE, RSP_I, RSP_D; next state each cycle = RSP_I if instr granted, RSP_D if data granted, else IDLE.
REQ-013 In RSP_I instr_rvalid_o=1; in RSP_D data_rvalid_o=1 (reads and writes alike); latency exactly 1 cycle gnt->rvalid.
REQ-014 instr_rdata_o and data_rdata_o SHALL both be driven from mem_rdata_i; content only meaningful with matching rvalid (write response rdata don't-care).
REQ-015 Back-to-back grants SHALL be supported every cycle (pipelined; full throughput 1 access/cycle).
REQ-016 Only one requester: it SHALL be granted regardless of priority state.
REQ-017 Simultaneous requests: arbitration per Configuration; loser sees gnt_o=0 and must hold request.
REQ-018 Neither requesting: mem_req_o=0, state -> IDLE, no rvalid next cycle.
REQ-019 Register last_winner (1 bit, 0=data, 1=instr) SHALL update only on contested cycles.

Reset
REQ-020 Asynchronous assertion of rst_sys_n SHALL force state IDLE, last_winner=1 (data wins first contest), both rvalid_o=0 immediately.
REQ-021 Grant pending at reset SHALL be dropped; no rvalid issued after reset release for it.
REQ-022 During reset gnt outputs remain combinational; environment holds requests low.

Configuration
REQ-023 Macro SRAM_ARB_ROUND_ROBIN_EN defined: contested cycle grants the port not equal to last_winner, then toggles last_winner.
REQ-024 Macro undefined: data port SHALL always win contests (fixed priority); last_winner unused; instr starvation under continuous data requests is accepted behaviour.

Verification
REQ-025 Instr-only: instr_req=1, addr 0x80 for 3 cycles -> instr_gnt=1 each cycle, mem_addr=0x20, instr_rvalid=1 cycles 1-3, rdata=RAM[0x20].
REQ-026 Data write then read: write 0xDEADBEEF be=4'b1111 to 0x100, next cycle read 0x100 -> data_rvalid both following cycles, second rdata=0xDEADBEEF.
REQ-027 Contest with RR enabled: both req held 4 cycles after reset -> grant order D,I,D,I; rvalids alternate data/instr one cycle later.
REQ-028 Contest with RR disabled: both req held 4 cycles -> data_gnt=1 all 4 cycles, instr_gnt=0, instr_rvalid never asserted.
REQ-029 Reset mid-operation: data read granted, rst_sys_n low next cycle -> data_rvalid=0 during and after reset, state IDLE.
REQ-030 Address wrap: data read addr 0x0001_0004 with MemDepth=16384 -> mem_addr_o=0x0001, rdata equals read of 0x4.
